// File: rtl/fp_sched_pkg.sv
// Shared definitions for the FP add/sub scheduler.
// Holds the controller state encoding and the IEEE-754 single-precision
// constants used by the special-operand classifier and the watchdog abort.
package fp_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_BYPASS = 3'd3,
      ST_RESP   = 3'd4
   } sched_state_t;

   localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
   localparam logic [7:0]  FP_EXP_ZERO = 8'h00;
   localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
   localparam logic [31:0] FP_ZERO     = 32'h0000_0000;

endpackage

// File: rtl/fp_special_classifier.sv
// Combinational operand classifier for the FP add/sub scheduler.
// Detects operand pairs the shared datapath does not handle (zero/subnormal
// exponent, Inf/NaN exponent) and produces the bypass result directly.
// Ports:
//   a, b            IEEE-754 single operands
//   op              0 = a+b, 1 = a-b
//   is_special      pair must bypass the datapath
//   special_result  result word to return when is_special is set
module fp_special_classifier
   import fp_sched_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        op,
   output logic        is_special,
   output logic [31:0] special_result
);

   logic [7:0] ea;
   logic [7:0] eb;
   logic       sb_eff;

   assign ea     = a[30:23];
   assign eb     = b[30:23];
   // Subtraction is addition of b with its sign flipped.
   assign sb_eff = b[31] ^ op;

   always_comb begin
      is_special     = 1'b1;
      special_result = FP_ZERO;
      if (ea == FP_EXP_MAX || eb == FP_EXP_MAX) begin
         special_result = FP_QNAN;
      end else if (ea == FP_EXP_ZERO && eb == FP_EXP_ZERO) begin
         special_result = FP_ZERO;
      end else if (ea == FP_EXP_ZERO) begin
         special_result = {sb_eff, b[30:0]};
      end else if (eb == FP_EXP_ZERO) begin
         special_result = a;
      end else begin
         is_special = 1'b0;
      end
   end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one multi-cycle FP add/sub datapath between two requesters.
// Round-robin arbitration in IDLE, operand registration, bypass of special
// operand classes, start pulse plus watchdog-guarded wait for done, and a
// single tagged response bus with backpressure.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req{0,1}_valid/_ready           request handshake per port
//   req{0,1}_a/_b/_op               operands and operation per port
//   dp_start, dp_a, dp_b, dp_op     datapath launch and registered operands
//   dp_done, dp_result              datapath completion and result
//   rsp_valid, rsp_ready            response handshake
//   rsp_id, rsp_result              requester index and result word
//   rsp_special, rsp_timeout        bypass-produced / watchdog-aborted flags
module fp_add_scheduler
   import fp_sched_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic        req1_op,
   output logic        dp_start,
   output logic [31:0] dp_a,
   output logic [31:0] dp_b,
   output logic        dp_op,
   input  logic        dp_done,
   input  logic [31:0] dp_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_special,
   output logic        rsp_timeout
);

   sched_state_t     state;
   logic             last_grant;
   logic             grant;
   logic             accept;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic             in_op;
   logic             is_special;
   logic [31:0]      special_result;
   logic [31:0]      byp_result;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;

   always_comb begin
      if (req0_valid && req1_valid) begin
         grant = ~last_grant;
      end else begin
         grant = req1_valid;
      end
   end

   assign accept     = (state == ST_IDLE) && (req0_valid || req1_valid);
   assign req0_ready = accept & ~grant;
   assign req1_ready = accept & grant;

   assign in_a  = grant ? req1_a  : req0_a;
   assign in_b  = grant ? req1_b  : req0_b;
   assign in_op = grant ? req1_op : req0_op;

   fp_special_classifier u_classifier (
      .a              (in_a),
      .b              (in_b),
      .op             (in_op),
      .is_special     (is_special),
      .special_result (special_result)
   );

   // The abort test looks at the incremented count so the response appears
   // exactly TIMEOUT_CYCLES cycles after the dp_start pulse.
   assign cnt_inc = cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         last_grant  <= 1'b1;
         dp_start    <= 1'b0;
         dp_a        <= '0;
         dp_b        <= '0;
         dp_op       <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_id      <= 1'b0;
         rsp_result  <= '0;
         rsp_special <= 1'b0;
         rsp_timeout <= 1'b0;
         byp_result  <= '0;
         cnt         <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  last_grant <= grant;
                  dp_a       <= in_a;
                  dp_b       <= in_b;
                  dp_op      <= in_op;
                  rsp_id     <= grant;
                  byp_result <= special_result;
                  if (is_special) begin
                     state <= ST_BYPASS;
                  end else begin
                     dp_start <= 1'b1;
                     state    <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               dp_start <= 1'b0;
               cnt      <= '0;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               cnt <= cnt_inc;
               // Done has priority over a simultaneous watchdog expiry.
               if (dp_done) begin
                  rsp_result  <= dp_result;
                  rsp_special <= 1'b0;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= ST_RESP;
               end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  rsp_result  <= FP_QNAN;
                  rsp_special <= 1'b0;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  state       <= ST_RESP;
               end
            end
            ST_BYPASS: begin
               rsp_result  <= byp_result;
               rsp_special <= 1'b1;
               rsp_timeout <= 1'b0;
               rsp_valid   <= 1'b1;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
